// File: rtl/num_2_ascii_dec.sv
// Binary-to-decimal ASCII converter: one character per commit, produced by
// repeated per-decade subtraction; optional sign, leading-zero blanking and overflow.
module num_2_ascii_dec #(
  parameter int IN_W     = 16,
  parameter int DIGITS   = 5,
  parameter int SIGNED   = 0,
  parameter int LZ_BLANK = 1,
  parameter int CAN_CT   = 8,
  parameter int AN_BASE  = 0,
  localparam int AN_W    = (CAN_CT > 1) ? $clog2(CAN_CT) : 1
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cvt_num,
  input  logic [IN_W-1:0] inputval,
  output logic [AN_W-1:0] an_sel,
  output logic [7:0]      ascii_lut_addr,
  output logic            commit,
  output logic            cvt_in_prog,
  output logic            cvt_done,
  output logic            overflow
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam int RW = IN_W + 1;
  localparam int PW = $clog2(LIMIT + 64'd1);
  localparam int CW = (RW > PW) ? RW : PW;
  localparam int KW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  // Decade power 10^k from a constant table indexed by the digit position.
  function automatic logic [CW-1:0] pwr_of(input logic [KW-1:0] k);
    logic [63:0] p;
    logic [CW-1:0] r;
    r = '0;
    p = 64'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (k == KW'(i)) r = p[CW-1:0];
      else r = r;
      p = p * 64'd10;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SIGN, S_DIGIT, S_STALL, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] val_q, val_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic            neg_q, neg_d;
  logic            nz_q, nz_d;
  logic            last_q, last_d;
  logic [AN_W-1:0] an_sel_q, an_sel_d;
  logic [7:0]      addr_q, addr_d;
  logic            commit_q, commit_d;
  logic            prog_q, prog_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic [RW-1:0]   val_ext_s, mag_s;
  logic            neg_s;
  logic [CW-1:0]   mag_ext_s, rem_ext_s, pwr_s, diff_s;

  // Magnitude at IN_W+1 bits so the most negative input negates exactly.
  always_comb begin
    neg_s     = (SIGNED != 0) && val_q[IN_W-1];
    val_ext_s = {neg_s, val_q};
    if (neg_s) mag_s = (~val_ext_s) + RW'(1'b1);
    else       mag_s = val_ext_s;
    mag_ext_s        = '0;
    mag_ext_s[RW-1:0] = mag_s;
    rem_ext_s        = '0;
    rem_ext_s[RW-1:0] = rem_q;
    pwr_s            = pwr_of(k_q);
    diff_s           = rem_ext_s - pwr_s;
  end

  // Next-state and output computation for the conversion sequencer.
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    neg_d    = neg_q;
    nz_d     = nz_q;
    last_d   = last_q;
    an_sel_d = an_sel_q;
    addr_d   = addr_q;
    commit_d = 1'b0;
    prog_d   = prog_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (cvt_num) begin
          val_d    = inputval;
          prog_d   = 1'b1;
          ovf_d    = 1'b0;
          an_sel_d = AN_W'(AN_BASE);
          cnt_d    = 4'd0;
          k_d      = KW'(DIGITS - 1);
          nz_d     = 1'b0;
          last_d   = 1'b0;
          state_d  = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        rem_d   = mag_s;
        neg_d   = neg_s;
        ovf_d   = (mag_ext_s >= LIMIT_C);
        state_d = (SIGNED != 0) ? S_SIGN : S_DIGIT;
      end
      S_SIGN: begin
        addr_d   = neg_q ? 8'h2D : 8'h20;
        commit_d = 1'b1;
        state_d  = S_STALL;
      end
      S_DIGIT: begin
        if (!ovf_q && (rem_ext_s >= pwr_s)) begin
          rem_d = diff_s[RW-1:0];
          cnt_d = cnt_q + 4'd1;
        end else begin
          if (ovf_q) addr_d = 8'h45;
          else if ((LZ_BLANK != 0) && !nz_q && (cnt_q == 4'd0) && (k_q != '0)) addr_d = 8'h20;
          else addr_d = 8'h30 + {4'h0, cnt_q};
          nz_d     = nz_q | (cnt_q != 4'd0);
          commit_d = 1'b1;
          cnt_d    = 4'd0;
          last_d   = (k_q == '0);
          if (k_q != '0) k_d = k_q - KW'(1);
          else k_d = k_q;
          state_d  = S_STALL;
        end
      end
      S_STALL: begin
        if (!last_q) begin
          an_sel_d = an_sel_q + AN_W'(1);
          state_d  = S_DIGIT;
        end else begin
          prog_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register: synchronous reset first, then hold whenever en is low.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      val_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= 4'd0;
      k_q      <= '0;
      neg_q    <= 1'b0;
      nz_q     <= 1'b0;
      last_q   <= 1'b0;
      an_sel_q <= AN_W'(AN_BASE);
      addr_q   <= 8'h00;
      commit_q <= 1'b0;
      prog_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      state_q  <= state_d;
      val_q    <= val_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      neg_q    <= neg_d;
      nz_q     <= nz_d;
      last_q   <= last_d;
      an_sel_q <= an_sel_d;
      addr_q   <= addr_d;
      commit_q <= commit_d;
      prog_q   <= prog_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign an_sel         = an_sel_q;
  assign ascii_lut_addr = addr_q;
  assign commit         = commit_q;
  assign cvt_in_prog    = prog_q;
  assign cvt_done       = done_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_num_2_ascii_dec.sv
// Scoreboard bench for num_2_ascii_dec: three configurations (default, signed,
// 3-digit) with expected characters modelled by division and pushed at start.
module tb_num_2_ascii_dec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en;
  logic cvt_a, cvt_s, cvt_o;
  logic [15:0] in_a, in_s;
  logic [9:0]  in_o;
  logic [2:0] an_a, an_s, an_o;
  logic [7:0] addr_a, addr_s, addr_o;
  logic com_a, com_s, com_o, prog_a, prog_s, prog_o;
  logic done_a, done_s, done_o, ovf_a, ovf_s, ovf_o;

  num_2_ascii_dec dut_a (
    .sys_clk(clk), .rst_n(rst_n), .en(en), .cvt_num(cvt_a), .inputval(in_a),
    .an_sel(an_a), .ascii_lut_addr(addr_a), .commit(com_a), .cvt_in_prog(prog_a),
    .cvt_done(done_a), .overflow(ovf_a));

  num_2_ascii_dec #(.IN_W(16), .DIGITS(5), .SIGNED(1)) dut_s (
    .sys_clk(clk), .rst_n(rst_n), .en(en), .cvt_num(cvt_s), .inputval(in_s),
    .an_sel(an_s), .ascii_lut_addr(addr_s), .commit(com_s), .cvt_in_prog(prog_s),
    .cvt_done(done_s), .overflow(ovf_s));

  num_2_ascii_dec #(.IN_W(10), .DIGITS(3)) dut_o (
    .sys_clk(clk), .rst_n(rst_n), .en(en), .cvt_num(cvt_o), .inputval(in_o),
    .an_sel(an_o), .ascii_lut_addr(addr_o), .commit(com_o), .cvt_in_prog(prog_o),
    .cvt_done(done_o), .overflow(ovf_o));

  typedef struct packed {
    logic [7:0] addr;
    logic [2:0] an;
  } exp_t;

  exp_t q [3][$];
  int total = 0;
  int bad   = 0;

  function automatic logic [14:0] outs(input int w);
    case (w)
      0:       return {an_a, addr_a, com_a, prog_a, done_a, ovf_a};
      1:       return {an_s, addr_s, com_s, prog_s, done_s, ovf_s};
      default: return {an_o, addr_o, com_o, prog_o, done_o, ovf_o};
    endcase
  endfunction

  task automatic set_cvt(input int w, input logic b);
    case (w)
      0:       cvt_a = b;
      1:       cvt_s = b;
      default: cvt_o = b;
    endcase
  endtask

  task automatic check_commit(input int w, input logic [7:0] addr, input logic [2:0] an);
    exp_t e;
    total++;
    if (q[w].size() == 0) begin
      bad++;
      $display("FAIL commit_unexpected dut%0d: got addr=%h an=%0d, expected no commit", w, addr, an);
    end else begin
      e = q[w].pop_front();
      if ({addr, an} !== e) begin
        bad++;
        $display("FAIL commit dut%0d: got addr=%h an=%0d, expected addr=%h an=%0d",
                 w, addr, an, e.addr, e.an);
      end
    end
  endtask

  // Consumer side: a commit counts once per enabled cycle.
  always @(negedge clk) begin
    if (en && com_a) check_commit(0, addr_a, an_a);
    if (en && com_s) check_commit(1, addr_s, an_s);
    if (en && com_o) check_commit(2, addr_o, an_o);
  end

  // Reference model: digits by division, pushes expected commits, returns latency.
  task automatic push_exp(input int w, input longint v, output int lat, output bit ovf);
    int digits, inw, d;
    bit sgn, neg, nz;
    longint mag, lim, pw;
    logic [7:0] ch;
    logic [2:0] an;
    digits = (w == 2) ? 3 : 5;
    inw    = (w == 2) ? 10 : 16;
    sgn    = (w == 1);
    neg    = sgn && v[inw-1];
    mag    = neg ? ((64'sd1 <<< inw) - v) : v;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ovf = (mag >= lim);
    lat = 1 + (sgn ? 2 : 0);
    an  = 3'd0;
    if (sgn) begin
      q[w].push_back('{addr: (neg ? 8'h2D : 8'h20), an: an});
      an = an + 3'd1;
    end
    nz = 1'b0;
    for (int i = digits - 1; i >= 0; i--) begin
      pw = 1;
      for (int j = 0; j < i; j++) pw = pw * 10;
      d = int'((mag / pw) % 10);
      if (ovf) begin
        ch = 8'h45;
        d  = 0;
      end else if (!nz && d == 0 && i > 0) ch = 8'h20;
      else ch = 8'h30 + d[7:0];
      if (d != 0) nz = 1'b1;
      q[w].push_back('{addr: ch, an: an});
      an  = an + 3'd1;
      lat = lat + d + 2;
    end
  endtask

  task automatic run_conv(input int w, input longint v, input int hold_at, input int busy_at);
    int lat, got;
    bit eovf;
    logic [14:0] snap;
    push_exp(w, v, lat, eovf);
    if (hold_at > 0) lat = lat + 5;
    case (w)
      0:       in_a = v[15:0];
      1:       in_s = v[15:0];
      default: in_o = v[9:0];
    endcase
    set_cvt(w, 1'b1);
    @(posedge clk); #1;
    set_cvt(w, 1'b0);
    got = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        total++;
        if (outs(w)[2] !== 1'b1) begin
          bad++;
          $display("FAIL busy dut%0d v=%0d: got cvt_in_prog=%b, expected 1", w, v, outs(w)[2]);
        end
      end
      if (hold_at > 0 && n > hold_at && n <= hold_at + 5) begin
        total++;
        if (outs(w) !== snap) begin
          bad++;
          $display("FAIL en_hold dut%0d cycle %0d: got %h, expected %h", w, n, outs(w), snap);
        end
      end
      if (hold_at > 0 && n == hold_at) begin
        snap = outs(w);
        en   = 1'b0;
      end
      if (hold_at > 0 && n == hold_at + 5) en = 1'b1;
      if (busy_at > 0) set_cvt(w, n == busy_at);
      if (outs(w)[1] === 1'b1) begin
        got = n;
        break;
      end
    end
    set_cvt(w, 1'b0);
    en = 1'b1;
    total++;
    if (got != lat) begin
      bad++;
      $display("FAIL latency dut%0d v=%0d: got %0d cycles, expected %0d", w, v, got, lat);
    end
    total++;
    if (outs(w)[0] !== eovf) begin
      bad++;
      $display("FAIL overflow dut%0d v=%0d: got %b, expected %b", w, v, outs(w)[0], eovf);
    end
    total++;
    if (q[w].size() != 0) begin
      bad++;
      $display("FAIL missing_commits dut%0d v=%0d: got %0d left over, expected 0", w, v, q[w].size());
    end
    q[w].delete();
    @(posedge clk); #1;
    total++;
    if (outs(w)[2:1] !== 2'b00) begin
      bad++;
      $display("FAIL done_pulse dut%0d v=%0d: got prog/done=%b, expected 00", w, v, outs(w)[2:1]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    cvt_a = 1'b0; cvt_s = 1'b0; cvt_o = 1'b0;
    in_a  = 16'd0; in_s = 16'd0; in_o = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      total++;
      if (outs(w) !== 15'd0) begin
        bad++;
        $display("FAIL reset dut%0d: got %h, expected 0000", w, outs(w));
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_conv(0, 12345, 0, 0);
  endtask

  task automatic test_boundary();
    run_conv(0, 10000, 0, 0);
    run_conv(0, 0, 0, 0);
    run_conv(0, 65535, 0, 0);
    run_conv(0, 9, 0, 0);
  endtask

  task automatic test_signed();
    run_conv(1, 16'h8000, 0, 0);
    run_conv(1, 16'hFFFF, 0, 0);
    run_conv(1, 32767, 0, 0);
    run_conv(1, 0, 0, 0);
  endtask

  task automatic test_overflow();
    run_conv(2, 1000, 0, 0);
    run_conv(2, 999, 0, 0);
    run_conv(2, 1023, 0, 0);
    run_conv(2, 5, 0, 0);
  endtask

  task automatic test_enable_hold();
    run_conv(0, 12345, 3, 0);
    run_conv(0, 40302, 0, 6);
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    bit eovf, saw_done;
    push_exp(0, 12345, lat, eovf);
    in_a  = 16'd12345;
    cvt_a = 1'b1;
    @(posedge clk); #1;
    cvt_a = 1'b0;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (com_a) seen++;
      if (seen == 3) break;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (outs(0) !== 15'd0 || seen != 3) begin
      bad++;
      $display("FAIL reset_mid: got outputs %h after %0d commits, expected 0000 after 3", outs(0), seen);
    end
    rst_n = 1'b1;
    q[0].delete();
    saw_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done_a || prog_a) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: got done/busy activity after reset, expected none");
    end
    run_conv(0, 54321, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_conv(0, longint'($urandom_range(0, 65535)), 0, 0);
    for (int i = 0; i < 3; i++) run_conv(1, longint'($urandom_range(0, 65535)), 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_signed();
    test_overflow();
    test_enable_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/num_2_ascii_dec.md
Name: num_2_ascii_dec

Overview:
Parametrised binary-to-decimal ASCII converter that feeds the 8-character 7-segment/ASCII LUT display path.
- Converts an IN_W-bit unsigned or two's-complement value into DIGITS decimal characters, plus an optional sign character.
- Uses iterative per-decade subtraction and emits one LUT address per character with a commit strobe.
- Adds signed mode, leading-zero blanking, overflow indication, configurable digit count and start position, and a done pulse.

Parameters:
- IN_W, 16: input width in bits.
- DIGITS, 5: number of decimal digit characters; DIGITS+SIGNED must be ≤ CAN_CT.
- SIGNED, 0: 1 = input is two's complement and a sign character precedes the digits.
- LZ_BLANK, 1: 1 = leading zeros are emitted as space (0x20); the least-significant digit is never blanked.
- CAN_CT, 8: number of display character positions.
- AN_BASE, 0: an_sel value of the first emitted character.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  clock enable; when 0, all state and outputs hold.
- cvt_num  in  1  start request; sampled only in IDLE.
- inputval  in  IN_W  value to convert; captured on start.
- an_sel  out  clog2(CAN_CT)  character position of the current commit.
- ascii_lut_addr  out  8  ASCII code of the current character.
- commit  out  1  one-cycle strobe: an_sel and ascii_lut_addr are valid.
- cvt_in_prog  out  1  conversion busy.
- cvt_done  out  1  one-cycle pulse when the last character has committed.
- overflow  out  1  the last conversion exceeded the DIGITS range; holds until the next start.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; an_sel=AN_BASE; ascii_lut_addr=0; commit=0; cvt_in_prog=0; cvt_done=0; overflow=0. Reset mid-conversion aborts the conversion with no commit or done pulse. Reset has priority over everything, including en.
- en=0: FSM, remainder, counter and all outputs hold. A commit or cvt_done that was high stays high; the consumer qualifies these with en.
- States: IDLE, LOAD, SIGN, DIGIT, STALL, DONE.
- IDLE: when cvt_num=1, capture inputval; set cvt_in_prog=1; clear overflow; an_sel=AN_BASE; go to LOAD. cvt_num in any other state is ignored.
- LOAD (1 cycle):
  - Magnitude = |inputval| computed at IN_W+1 bits, so the most negative value is exact; plain value when SIGNED=0.
  - If magnitude ≥ 10^DIGITS, set overflow=1.
  - Go to SIGN if SIGNED, else DIGIT.
- SIGN: ascii_lut_addr = 0x2D ('-') if negative, else 0x20; commit<=1; go to STALL.
- DIGIT (decade power P = 10^k, k from DIGITS-1 down to 0, from a constant table):
  - If overflow: emit 0x45 ('E') immediately.
  - Else, while remainder ≥ P (greater-or-equal comparison): subtract P and increment the counter, one cycle per subtraction.
  - When remainder < P: emit the character — 0x30+count, or 0x20 if LZ_BLANK, no nonzero digit has been emitted yet, and k>0. Set commit<=1; reset the counter; go to STALL.
- STALL (1 cycle): commit<=0.
  - If characters remain: an_sel<=an_sel+1 and return to DIGIT.
  - Else: cvt_in_prog<=0, cvt_done<=1, go to DONE.
- DONE (1 cycle): cvt_done<=0; go to IDLE. A new start is accepted in the cycle after DONE.
- Commit timing: commit is high exactly one cycle per character. During that cycle, an_sel equals that character's position (AN_BASE + index).
- Latency: cvt_done is high in cycle 1 + 2·SIGNED + Σ(d_k + 2) after the start edge, where d_k is each digit value; d_k = 0 for every position on overflow.
- Arithmetic widths:
  - Remainder is IN_W+1 bits.
  - Counter is 4 bits; it never exceeds 9 unless overflow is set, and the overflow path bypasses counting.
  - The power table is sized to clog2(10^DIGITS) bits; comparisons zero-extend to the wider operand.

Test Plan:
1. Defaults, inputval=12345, start: five commits with addr 0x31,0x32,0x33,0x34,0x35 and an_sel 0..4; cvt_done 26 cycles after the start edge; overflow=0.
2. Defaults, inputval=10000, then 0, then 65535: 10000 → "10000" (boundary ≥); 0 → 0x20×4 then 0x30; 65535 → "65535".
3. SIGNED=1, IN_W=16, inputval=16'h8000: six commits '-','3','2','7','6','8' (0x2D,0x33,0x32,0x37,0x36,0x38); inputval=16'hFFFF → '-', 0x20×3, 0x20, 0x31.
4. DIGITS=3, IN_W=10, inputval=1000: overflow=1, commits 0x45×3, done 7 cycles after start; next start with 999 clears overflow and emits "999".
5. Hold en=0 for 5 cycles mid-conversion: outputs frozen, final character sequence identical, done delayed by exactly 5 cycles. Pulse cvt_num while busy: ignored, no restart.
6. Assert rst_n=0 at the 3rd commit: next cycle all outputs at reset values, no cvt_done. Start after release: a clean full conversion.
